// File: rtl/mux2_arbiter.sv
// Round-robin arbiter sharing one 8-bit 2:1 byte mux between two bursting requesters.
// Optional idle-owner forced release is built only when ARB_TIMEOUT_EN is defined.
module mux2_arbiter #(
  parameter int unsigned P_TIMEOUT = 15
) (
  input  logic       iCLOCK,
  input  logic       inRESET,
  input  logic       iVALID0,
  input  logic [7:0] iDATA0,
  input  logic       iLAST0,
  output logic       oREADY0,
  input  logic       iVALID1,
  input  logic [7:0] iDATA1,
  input  logic       iLAST1,
  output logic       oREADY1,
  output logic       oVALID,
  output logic [7:0] oDATA,
  output logic       oLAST,
  input  logic       iREADY,
  output logic       oSELECT,
  output logic       oBUSY,
  output logic       oTIMEOUT
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOwn0 = 2'd1;
  localparam logic [1:0] StOwn1 = 2'd2;

  logic [1:0] stateQ, stateD;
  logic       selectQ, selectD;
  logic       lastOwnerQ, lastOwnerD;
  logic       own0, own1, ownerValid, lastXfer, forceRelease, grantDone;

  assign own0       = (stateQ == StOwn0);
  assign own1       = (stateQ == StOwn1);
  assign ownerValid = (own0 & iVALID0) | (own1 & iVALID1);
  assign lastXfer   = iREADY & ((own0 & iVALID0 & iLAST0) | (own1 & iVALID1 & iLAST1));
  assign grantDone  = lastXfer | forceRelease;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cntQ, cntD;

  // Release on the idle cycle that brings the count up to P_TIMEOUT.
  assign forceRelease = (own0 | own1) & ~ownerValid & (cntQ == 8'(P_TIMEOUT - 1));

  always_comb begin
    cntD = cntQ + 8'd1;
    if ((stateD != stateQ) || ownerValid || !(own0 | own1)) begin
      cntD = 8'd0;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      cntQ <= 8'd0;
    end else begin
      cntQ <= cntD;
    end
  end
`else
  logic unusedTimeout;

  assign forceRelease  = 1'b0;
  assign unusedTimeout = (P_TIMEOUT != 0);
`endif

  always_comb begin
    stateD     = stateQ;
    selectD    = selectQ;
    lastOwnerD = lastOwnerQ;
    case (stateQ)
      StIdle: begin
        // lastOwnerQ==1 means requester 0 has priority on a tie.
        if (iVALID0 && (!iVALID1 || lastOwnerQ)) begin
          stateD  = StOwn0;
          selectD = 1'b0;
        end else if (iVALID1) begin
          stateD  = StOwn1;
          selectD = 1'b1;
        end
      end
      StOwn0: begin
        if (grantDone) begin
          lastOwnerD = 1'b0;
          if (iVALID1) begin
            stateD  = StOwn1;
            selectD = 1'b1;
          end else begin
            stateD = StIdle;
          end
        end
      end
      StOwn1: begin
        if (grantDone) begin
          lastOwnerD = 1'b1;
          if (iVALID0) begin
            stateD  = StOwn0;
            selectD = 1'b0;
          end else begin
            stateD = StIdle;
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      stateQ     <= StIdle;
      selectQ    <= 1'b0;
      lastOwnerQ <= 1'b1;
    end else begin
      stateQ     <= stateD;
      selectQ    <= selectD;
      lastOwnerQ <= lastOwnerD;
    end
  end

  assign oDATA    = selectQ ? iDATA1 : iDATA0;
  assign oLAST    = selectQ ? iLAST1 : iLAST0;
  assign oVALID   = ownerValid;
  assign oREADY0  = own0 & iREADY;
  assign oREADY1  = own1 & iREADY;
  assign oSELECT  = selectQ;
  assign oBUSY    = (stateQ != StIdle);
  assign oTIMEOUT = forceRelease;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: reset, bursts, round-robin handoff, stalls, mid-burst
// reset and idle-owner release (checked according to whether ARB_TIMEOUT_EN is defined).
module tb_mux2_arbiter;

  logic       iCLOCK, inRESET;
  logic       iVALID0, iLAST0, iVALID1, iLAST1, iREADY;
  logic [7:0] iDATA0, iDATA1;
  logic       oREADY0, oREADY1, oVALID, oLAST, oSELECT, oBUSY, oTIMEOUT;
  logic [7:0] oDATA;

  int errors = 0;
  int checks = 0;

  mux2_arbiter #(.P_TIMEOUT(4)) dut (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .iVALID0 (iVALID0),
    .iDATA0  (iDATA0),
    .iLAST0  (iLAST0),
    .oREADY0 (oREADY0),
    .iVALID1 (iVALID1),
    .iDATA1  (iDATA1),
    .iLAST1  (iLAST1),
    .oREADY1 (oREADY1),
    .oVALID  (oVALID),
    .oDATA   (oDATA),
    .oLAST   (oLAST),
    .iREADY  (iREADY),
    .oSELECT (oSELECT),
    .oBUSY   (oBUSY),
    .oTIMEOUT(oTIMEOUT)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic nextCycle();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic doReset();
    inRESET = 1'b0;
    iVALID0 = 1'b0; iDATA0 = 8'h00; iLAST0 = 1'b0;
    iVALID1 = 1'b0; iDATA1 = 8'h00; iLAST1 = 1'b0;
    iREADY  = 1'b0;
    repeat (2) @(posedge iCLOCK);
    @(negedge iCLOCK);
    inRESET = 1'b1;
    nextCycle();
  endtask

  task automatic test_reset();
    inRESET = 1'b0;
    iVALID0 = 1'b1; iDATA0 = 8'h55; iLAST0 = 1'b0;
    iVALID1 = 1'b1; iDATA1 = 8'h66; iLAST1 = 1'b0;
    iREADY  = 1'b1;
    repeat (2) @(posedge iCLOCK);
    @(negedge iCLOCK);
    checks++; if (oVALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", oVALID); end
    checks++; if (oREADY0 !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", oREADY0); end
    checks++; if (oREADY1 !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b want 0", oREADY1); end
    checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", oBUSY); end
    checks++; if (oTIMEOUT !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", oTIMEOUT); end
    checks++; if (oSELECT !== 1'b0) begin errors++; $display("FAIL reset_select: got %b want 0", oSELECT); end
  endtask

  task automatic test_single_burst();
    doReset();
    iVALID0 = 1'b1; iDATA0 = 8'h11; iLAST0 = 1'b0; iREADY = 1'b1;
    @(negedge iCLOCK);
    checks++; if (oREADY0 !== 1'b0) begin errors++; $display("FAIL single_grant_lat: oREADY0 got %b want 0", oREADY0); end
    checks++; if (oVALID !== 1'b0) begin errors++; $display("FAIL single_idle_valid: got %b want 0", oVALID); end
    nextCycle();
    @(negedge iCLOCK);
    checks++; if (oREADY0 !== 1'b1) begin errors++; $display("FAIL single_ready0: got %b want 1", oREADY0); end
    checks++; if (oDATA !== 8'h11) begin errors++; $display("FAIL single_byte0: got %h want 11", oDATA); end
    checks++; if (oSELECT !== 1'b0) begin errors++; $display("FAIL single_select: got %b want 0", oSELECT); end
    checks++; if (oBUSY !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", oBUSY); end
    nextCycle();
    iDATA0 = 8'h22; iLAST0 = 1'b1;
    @(negedge iCLOCK);
    checks++; if (oDATA !== 8'h22) begin errors++; $display("FAIL single_byte1: got %h want 22", oDATA); end
    checks++; if (oLAST !== 1'b1) begin errors++; $display("FAIL single_last: got %b want 1", oLAST); end
    nextCycle();
    iVALID0 = 1'b0; iLAST0 = 1'b0;
    @(negedge iCLOCK);
    checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL single_idle_after: busy got %b want 0", oBUSY); end
    checks++; if (oSELECT !== 1'b0) begin errors++; $display("FAIL single_sel_hold: got %b want 0", oSELECT); end
  endtask

  task automatic test_round_robin();
    logic [7:0] expData [8];
    logic       expSel  [8];
    logic       idx0, idx1, x0, x1;
    expData = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA0, 8'hA1, 8'hB0, 8'hB1};
    expSel  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    idx0 = 1'b0; idx1 = 1'b0;
    doReset();
    iVALID0 = 1'b1; iDATA0 = 8'hA0; iLAST0 = 1'b0;
    iVALID1 = 1'b1; iDATA1 = 8'hB0; iLAST1 = 1'b0;
    iREADY  = 1'b1;
    @(negedge iCLOCK);
    checks++; if (oVALID !== 1'b0) begin errors++; $display("FAIL rr_grant_lat: valid got %b want 0", oVALID); end
    x0 = oREADY0 & iVALID0;
    x1 = oREADY1 & iVALID1;
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      if (x0) idx0 = ~idx0;
      if (x1) idx1 = ~idx1;
      iDATA0 = idx0 ? 8'hA1 : 8'hA0; iLAST0 = idx0;
      iDATA1 = idx1 ? 8'hB1 : 8'hB0; iLAST1 = idx1;
      @(negedge iCLOCK);
      checks++;
      if (oVALID !== 1'b1 || oDATA !== expData[i] || oSELECT !== expSel[i]) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got valid=%b data=%h sel=%b want valid=1 data=%h sel=%b",
                 i, oVALID, oDATA, oSELECT, expData[i], expSel[i]);
      end
      x0 = oREADY0 & iVALID0;
      x1 = oREADY1 & iVALID1;
    end
  endtask

  task automatic test_stall();
    doReset();
    iVALID1 = 1'b1; iDATA1 = 8'hB0; iLAST1 = 1'b0; iREADY = 1'b1;
    @(negedge iCLOCK);
    nextCycle();
    iREADY = 1'b0;
    iVALID0 = 1'b1; iDATA0 = 8'hA0; iLAST0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge iCLOCK);
      checks++;
      if (oDATA !== 8'hB0 || oREADY1 !== 1'b0 || oSELECT !== 1'b1 || oREADY0 !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: got data=%h rdy1=%b sel=%b rdy0=%b want B0 0 1 0",
                 k, oDATA, oREADY1, oSELECT, oREADY0);
      end
      nextCycle();
    end
    iREADY = 1'b1;
    @(negedge iCLOCK);
    checks++; if (oREADY1 !== 1'b1 || oDATA !== 8'hB0) begin errors++; $display("FAIL stall_resume: got rdy1=%b data=%h want 1 B0", oREADY1, oDATA); end
    nextCycle();
    iDATA1 = 8'hB1; iLAST1 = 1'b1;
    @(negedge iCLOCK);
    checks++; if (oDATA !== 8'hB1 || oSELECT !== 1'b1) begin errors++; $display("FAIL stall_byte1: got data=%h sel=%b want B1 1", oDATA, oSELECT); end
    nextCycle();
    iVALID1 = 1'b0; iLAST1 = 1'b0;
    @(negedge iCLOCK);
    checks++;
    if (oSELECT !== 1'b0 || oDATA !== 8'hA0 || oREADY0 !== 1'b1) begin
      errors++;
      $display("FAIL stall_handoff: got sel=%b data=%h rdy0=%b want 0 A0 1", oSELECT, oDATA, oREADY0);
    end
  endtask

  task automatic test_reset_midburst();
    doReset();
    iVALID1 = 1'b1; iDATA1 = 8'hB0; iLAST1 = 1'b0; iREADY = 1'b1;
    @(negedge iCLOCK);
    nextCycle();
    nextCycle();
    iDATA1 = 8'hB1;
    #2;
    checks++; if (oVALID !== 1'b1 || oBUSY !== 1'b1) begin errors++; $display("FAIL mid_pre: got valid=%b busy=%b want 1 1", oVALID, oBUSY); end
    inRESET = 1'b0;
    #1;
    checks++; if (oVALID !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", oVALID); end
    checks++; if (oREADY1 !== 1'b0) begin errors++; $display("FAIL mid_ready1: got %b want 0", oREADY1); end
    checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", oBUSY); end
    checks++; if (oSELECT !== 1'b0) begin errors++; $display("FAIL mid_select: got %b want 0", oSELECT); end
    @(negedge iCLOCK);
    inRESET = 1'b1;
    iVALID0 = 1'b1; iDATA0 = 8'hA0; iLAST0 = 1'b1;
    nextCycle();
    @(negedge iCLOCK);
    checks++;
    if (oSELECT !== 1'b0 || oREADY0 !== 1'b1 || oDATA !== 8'hA0) begin
      errors++;
      $display("FAIL mid_after: got sel=%b rdy0=%b data=%h want 0 1 A0", oSELECT, oREADY0, oDATA);
    end
  endtask

  task automatic test_timeout();
    doReset();
    iVALID0 = 1'b1; iDATA0 = 8'hA0; iLAST0 = 1'b0;
    iVALID1 = 1'b1; iDATA1 = 8'hB0; iLAST1 = 1'b0;
    iREADY  = 1'b1;
    @(negedge iCLOCK);
    nextCycle();
    @(negedge iCLOCK);
    checks++; if (oREADY0 !== 1'b1 || oDATA !== 8'hA0) begin errors++; $display("FAIL to_first: got rdy0=%b data=%h want 1 A0", oREADY0, oDATA); end
    nextCycle();
    iVALID0 = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge iCLOCK);
      checks++;
      if (oTIMEOUT !== 1'b0 || oSELECT !== 1'b0) begin
        errors++;
        $display("FAIL to_wait[%0d]: got tmo=%b sel=%b want 0 0", k, oTIMEOUT, oSELECT);
      end
      nextCycle();
    end
    @(negedge iCLOCK);
    checks++; if (oTIMEOUT !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", oTIMEOUT); end
    nextCycle();
    @(negedge iCLOCK);
    checks++;
    if (oTIMEOUT !== 1'b0 || oSELECT !== 1'b1 || oREADY1 !== 1'b1 || oDATA !== 8'hB0) begin
      errors++;
      $display("FAIL to_handoff: got tmo=%b sel=%b rdy1=%b data=%h want 0 1 1 B0",
               oTIMEOUT, oSELECT, oREADY1, oDATA);
    end
`else
    for (int k = 0; k < 10; k++) begin
      @(negedge iCLOCK);
      checks++;
      if (oTIMEOUT !== 1'b0 || oSELECT !== 1'b0 || oBUSY !== 1'b1 || oREADY1 !== 1'b0) begin
        errors++;
        $display("FAIL noto_hold[%0d]: got tmo=%b sel=%b busy=%b rdy1=%b want 0 0 1 0",
                 k, oTIMEOUT, oSELECT, oBUSY, oREADY1);
      end
      nextCycle();
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_stall();
    test_reset_midburst();
    test_timeout();
    iVALID0 = 1'b0;
    iVALID1 = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
